light_sequencer: RTL and testbench

//  Controller for the lights selector datapath. Drives the colour counter's advance
//  (button) input and the white/colour mux select (sel). Debounces two raw push-buttons
//  and runs a white -> auto-cycle -> paused/manual-step state machine with a dwell timer.

---
 rtl/light_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_light_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// Debounced mode/step buttons drive a WHITE -> RUN -> PAUSE light sequencer; outputs are registered and change with the state.
// Button press to edge pulse is 2 + DEB_CYC cycles; LIGHT_SEQ_FLASH_EN adds a FLASH state on the 6->1 wrap in RUN.
module light_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int DWELL_CYC = 20,
  parameter int DEB_CYC   = 4,
  parameter int FLASH_CYC = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       mode_btn,
  input  logic       step_btn,
  output logic       advance,
  output logic       sel,
  output logic [2:0] colour_idx,
  output logic       running
);

  if (DWELL_CYC < 2 || DEB_CYC < 1 || DEB_CYC > 15 || FLASH_CYC < 1) begin : g_param_check
    $error("light_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {S_WHITE, S_RUN, S_PAUSE, S_FLASH} state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [3:0]         DEB_LAST   = 4'(DEB_CYC - 1);

  // Index 0 is the mode button, index 1 the step button.
  logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d, edge_q, edge_d;
  logic [1:0][3:0] deb_cnt_q, deb_cnt_d;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               advance_q, advance_d;
  logic               sel_q, sel_d;
  logic               running_q, running_d;
  logic [2:0]         colour_q, colour_d;
  logic               mode_edge, step_edge;

`ifdef LIGHT_SEQ_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_CYC + 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYC - 1);
  logic [FLASH_W-1:0] flash_q, flash_d;
`endif

  always_comb begin
    sync1_d = {step_btn, mode_btn};
    sync2_d = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    edge_d    = '0;
    for (int i = 0; i < 2; i++) begin
      // The count only survives while the synchronised level keeps disagreeing.
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
      edge_d[i] = deb_d[i] & ~deb_q[i];
    end
  end

  assign mode_edge = edge_q[0];
  assign step_edge = edge_q[1];

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    advance_d = 1'b0;
`ifdef LIGHT_SEQ_FLASH_EN
    flash_d   = flash_q;
`endif
    if (!enable) begin
      state_d = S_WHITE;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_WHITE: begin
          if (mode_edge) begin
            state_d = S_RUN;
            dwell_d = '0;
          end
        end
        S_RUN: begin
          // A mode edge wins over a dwell terminal in the same cycle.
          if (mode_edge) begin
            state_d = S_PAUSE;
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            advance_d = 1'b1;
            dwell_d   = '0;
`ifdef LIGHT_SEQ_FLASH_EN
            if (colour_q == 3'd6) begin
              state_d = S_FLASH;
              flash_d = '0;
            end
`endif
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        S_PAUSE: begin
          dwell_d = '0;
          if (mode_edge) begin
            state_d = S_WHITE;
          end else if (step_edge) begin
            advance_d = 1'b1;
          end
        end
`ifdef LIGHT_SEQ_FLASH_EN
        S_FLASH: begin
          if (mode_edge) begin
            state_d = S_PAUSE;
            dwell_d = '0;
          end else if (flash_q == FLASH_LAST) begin
            state_d = S_RUN;
            dwell_d = '0;
          end else begin
            flash_d = flash_q + FLASH_W'(1);
          end
        end
`endif
        default: begin
          state_d = S_WHITE;
          dwell_d = '0;
        end
      endcase
    end

    colour_d = colour_q;
    if (advance_d) begin
      colour_d = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
    end
    sel_d     = (state_d == S_RUN) || (state_d == S_PAUSE);
    running_d = (state_d == S_RUN) || (state_d == S_FLASH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_cnt_q <= '0;
      edge_q    <= '0;
      state_q   <= S_WHITE;
      dwell_q   <= '0;
      advance_q <= 1'b0;
      sel_q     <= 1'b0;
      running_q <= 1'b0;
      colour_q  <= 3'd1;
`ifdef LIGHT_SEQ_FLASH_EN
      flash_q   <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      advance_q <= advance_d;
      sel_q     <= sel_d;
      running_q <= running_d;
      colour_q  <= colour_d;
`ifdef LIGHT_SEQ_FLASH_EN
      flash_q   <= flash_d;
`endif
    end
  end

  assign advance    = advance_q;
  assign sel        = sel_q;
  assign colour_idx = colour_q;
  assign running    = running_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: timestamp-based reference model compared every cycle, directed scenarios, then random buttons/enable.
module tb_light_sequencer;
  localparam int DWELL_CYC = 20;
  localparam int DEB_CYC   = 4;
  localparam int FLASH_CYC = 6;
  localparam int N         = 8192;
  localparam int WH = 0, RU = 1, PA = 2, FL = 3;
`ifdef LIGHT_SEQ_FLASH_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, mode_btn, step_btn;
  logic       advance, sel, running;
  logic [2:0] colour_idx;

  light_sequencer #(
    .DWELL_W(8), .DWELL_CYC(DWELL_CYC), .DEB_CYC(DEB_CYC), .FLASH_CYC(FLASH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_btn(mode_btn), .step_btn(step_btn),
    .advance(advance), .sel(sel), .colour_idx(colour_idx), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: raw button history per clock edge, debounced level as a window test,
  // and RUN/FLASH timing held as absolute due-edge timestamps.
  bit r_mode [N];
  bit r_step [N];
  int k = 10;
  bit lvl [2];
  int lastf [2] = '{-100, -100};
  bit pend [2];
  int st = WH;
  int due = 0;
  int fend = 0;
  int m_colour = 1;
  bit m_adv = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit rv, input bit ev, input bit mb, input bit sb);
    bit me, se, all_diff, smp;
    k++;
    if (!rv) begin
      r_mode[k] = 1'b0;
      r_step[k] = 1'b0;
      for (int b = 0; b < 2; b++) begin
        lvl[b] = 1'b0; lastf[b] = -100; pend[b] = 1'b0;
      end
      st = WH; m_colour = 1; m_adv = 1'b0;
      return;
    end
    r_mode[k] = mb;
    r_step[k] = sb;
    me = pend[0];
    se = pend[1];
    m_adv = 1'b0;
    if (!ev) begin
      st = WH;
    end else begin
      case (st)
        WH: if (me) begin st = RU; due = k + DWELL_CYC; end
        RU: begin
          if (me) st = PA;
          else if (k == due) begin
            m_adv = 1'b1;
            due = k + DWELL_CYC;
            if (FL_EN && m_colour == 6) begin st = FL; fend = k + FLASH_CYC; end
          end
        end
        PA: begin
          if (me) st = WH;
          else if (se) m_adv = 1'b1;
        end
        default: begin
          if (me) st = PA;
          else if (k == fend) begin st = RU; due = k + DWELL_CYC; end
        end
      endcase
    end
    if (m_adv) m_colour = (m_colour == 6) ? 1 : m_colour + 1;
    // The debounced level flips once the last DEB_CYC synchronised samples (two edges old)
    // all disagree with it and none of them predates the previous flip.
    for (int b = 0; b < 2; b++) begin
      all_diff = (lastf[b] <= k - DEB_CYC);
      for (int j = 0; j < DEB_CYC; j++) begin
        smp = (b == 0) ? r_mode[k-2-j] : r_step[k-2-j];
        if (smp == lvl[b]) all_diff = 1'b0;
      end
      pend[b] = 1'b0;
      if (all_diff) begin
        lvl[b] = !lvl[b];
        lastf[b] = k;
        pend[b] = lvl[b];
      end
    end
  endtask

  task automatic tick();
    bit rv, ev, mb, sb;
    rv = rst; ev = enable; mb = mode_btn; sb = step_btn;
    @(posedge clk);
    #1;
    cyc++;
    model_step(rv, ev, mb, sb);
    check("advance", int'(advance), int'(m_adv));
    check("sel", int'(sel), (st == RU || st == PA) ? 1 : 0);
    check("running", int'(running), (st == RU || st == FL) ? 1 : 0);
    check("colour_idx", int'(colour_idx), m_colour);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ticks_count(input int n, inout int cnt);
    for (int i = 0; i < n; i++) begin
      tick();
      if (advance === 1'b1) cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ticks(3);
    rst = 1'b1;
    tick();
  endtask

  int adv_cnt;
  int mleft, sleft, eleft;

  initial begin
    rst = 1'b0; enable = 1'b1; mode_btn = 1'b0; step_btn = 1'b0;
    do_reset();
    check("reset_sel", int'(sel), 0);
    check("reset_advance", int'(advance), 0);
    check("reset_colour", int'(colour_idx), 1);
    check("reset_running", int'(running), 0);

    // Mode press from WHITE: edge 6 cycles after press, sel the cycle after.
    mode_btn = 1'b1;
    ticks(6);
    check("press_sel_early", int'(sel), 0);
    tick();
    check("press_sel", int'(sel), 1);
    check("press_running", int'(running), 1);
    ticks(3);
    mode_btn = 1'b0;
    ticks(16);
    check("first_adv_early", int'(advance), 0);
    tick();
    check("first_adv", int'(advance), 1);
    check("first_adv_colour", int'(colour_idx), 2);
    ticks(40);
    check("colour_before_rst", int'(colour_idx), 4);
    // Asynchronous reset in the middle of a cycle.
    #3 rst = 1'b0;
    #1;
    check("async_rst_sel", int'(sel), 0);
    check("async_rst_advance", int'(advance), 0);
    check("async_rst_colour", int'(colour_idx), 1);
    check("async_rst_running", int'(running), 0);
    ticks(3);
    rst = 1'b1;
    tick();

    // Glitch shorter than the debounce window.
    mode_btn = 1'b1;
    ticks(3);
    mode_btn = 1'b0;
    ticks(15);
    check("glitch_sel", int'(sel), 0);
    check("glitch_running", int'(running), 0);

    // Enter RUN, then a mode edge landing exactly on the first dwell terminal.
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(10);
    mode_btn = 1'b1; ticks(6);
    check("run_before_pause", int'(running), 1);
    tick();
    check("pause_no_adv", int'(advance), 0);
    check("pause_running", int'(running), 0);
    check("pause_sel", int'(sel), 1);
    check("pause_colour", int'(colour_idx), 1);
    ticks(3);
    mode_btn = 1'b0;
    ticks(10);

    // Three manual steps in PAUSE.
    adv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1; ticks_count(8, adv_cnt);
      step_btn = 1'b0; ticks_count(12, adv_cnt);
    end
    check("step_count", adv_cnt, 3);
    check("step_colour", int'(colour_idx), 4);

    // PAUSE -> WHITE, then a step in WHITE is ignored.
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(10);
    check("pause_to_white_sel", int'(sel), 0);
    adv_cnt = 0;
    step_btn = 1'b1; ticks_count(8, adv_cnt);
    step_btn = 1'b0; ticks_count(12, adv_cnt);
    check("white_step_ignored", adv_cnt, 0);

    // enable=0 in RUN forces WHITE, holds colour, and swallows mode edges.
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(25);
    check("run_again_colour", int'(colour_idx), 5);
    check("run_again_sel", int'(sel), 1);
    enable = 1'b0;
    tick();
    check("disable_sel", int'(sel), 0);
    check("disable_running", int'(running), 0);
    check("disable_colour", int'(colour_idx), 5);
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(10);
    check("disabled_mode_ignored", int'(sel), 0);
    enable = 1'b1;
    ticks(10);
    check("reenable_still_white", int'(sel), 0);
    check("reenable_colour", int'(colour_idx), 5);

    // Colour wrap 6 -> 1 in RUN, with and without the flash state.
    do_reset();
    mode_btn = 1'b1; ticks(10);
    mode_btn = 1'b0; ticks(116);
    check("pre_wrap_colour", int'(colour_idx), 6);
    tick();
    check("wrap_adv", int'(advance), 1);
    check("wrap_colour", int'(colour_idx), 1);
    check("wrap_sel", int'(sel), FL_EN ? 0 : 1);
    check("wrap_running", int'(running), 1);
    ticks(5);
    check("wrap_sel_end", int'(sel), FL_EN ? 0 : 1);
    tick();
    check("post_flash_sel", int'(sel), 1);
    ticks(13);
    check("post_wrap_adv_146", int'(advance), 0);
    tick();
    check("post_wrap_adv_147", int'(advance), FL_EN ? 0 : 1);
    ticks(5);
    tick();
    check("post_wrap_adv_153", int'(advance), FL_EN ? 1 : 0);

    // Random buttons and enable drops against the model.
    mleft = 0; sleft = 0; eleft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mleft == 0) begin
        mode_btn = !mode_btn;
        mleft = mode_btn ? int'($urandom_range(1, 12)) : int'($urandom_range(3, 60));
      end
      if (sleft == 0) begin
        step_btn = !step_btn;
        sleft = step_btn ? int'($urandom_range(1, 10)) : int'($urandom_range(3, 40));
      end
      if (eleft == 0) begin
        enable = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
        eleft = enable ? int'($urandom_range(20, 200)) : int'($urandom_range(1, 6));
      end
      mleft--; sleft--; eleft--;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
